// File: rtl/aes_key_sched_ctrl_if.sv
// Control and round-key read bus of the AES key-schedule controller.
// master = key consumer / cipher datapath, slave = aes_key_sched_ctrl.
interface aes_key_sched_ctrl_if #(
   parameter int NK = 4
) ();
   logic              start;
   logic [32*NK-1:0]  key;
   logic              busy;
   logic              done;
   logic              key_ready;
   logic              rk_req;
   logic [3:0]        rk_idx;
   logic              rk_valid;
   logic [127:0]      rk_data;
   logic              rk_err;

   modport master (
      output start, key, rk_req, rk_idx,
      input  busy, done, key_ready, rk_valid, rk_data, rk_err
   );

   modport slave (
      input  start, key, rk_req, rk_idx,
      output busy, done, key_ready, rk_valid, rk_data, rk_err
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES key expansion (one word per clock, one shared SubWord) with an indexed
// round-key read port. Define KEY_SCHED_REUSE_EN to skip re-expansion of an identical key.
module aes_key_sched_ctrl #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic                clk,
   input  logic                rst,
   aes_key_sched_ctrl_if.slave bus
);
   localparam int TOTAL = 4 * (NR + 1);
   localparam int IW    = $clog2(TOTAL + 1);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_e;

   state_e          state_q, state_d;
   logic [31:0]     wbuf_q [TOTAL];
   logic [IW-1:0]   i_q;
   logic [2:0]      k_q;
   logic [7:0]      rcon_q;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            key_ready_q, key_ready_d;
   logic            rk_valid_q, rk_valid_d;
   logic            rk_err_q, rk_err_d;
   logic [127:0]    rk_data_q;
   logic            accept_start, reuse_hit, load_go, exp_last, wr_en;
   logic [31:0]     prev_w, old_w, sub_in, sub_out, temp_w, new_w;
   logic [IW-1:0]   rd_base;

   // Table byte x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef KEY_SCHED_REUSE_EN
   logic [32*NK-1:0] key_q;

   always_ff @(posedge clk) begin
      if (load_go) key_q <= bus.key;
   end

   assign reuse_hit = (state_q == READY) && (bus.key == key_q);
`else
   assign reuse_hit = 1'b0;
`endif

   assign accept_start = bus.start && ((state_q == IDLE) || (state_q == READY));
   assign load_go      = accept_start && !reuse_hit;

   // k_q tracks i mod NK so NK=6 needs no divider.
   always_comb begin
      prev_w  = wbuf_q[i_q - IW'(1)];
      old_w   = wbuf_q[i_q - IW'(NK)];
      sub_in  = (k_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = subword(sub_in);
      if (k_q == 3'd0)
         temp_w = sub_out ^ {rcon_q, 24'h0};
      else if ((NK > 6) && (k_q == 3'd4))
         temp_w = sub_out;
      else
         temp_w = prev_w;
      new_w   = old_w ^ temp_w;
      rd_base = IW'({bus.rk_idx, 2'b00});
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_go) state_d = LOAD;
         LOAD:    state_d = EXPAND;
         EXPAND:  if (i_q == IW'(TOTAL)) state_d = READY;
         READY:   if (load_go) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // The extra EXPAND cycle at i==TOTAL is the hand-off into READY.
   always_comb begin
      exp_last    = (state_q == EXPAND) && (i_q == IW'(TOTAL));
      wr_en       = (state_q == EXPAND) && (i_q != IW'(TOTAL));
      busy_d      = busy_q;
      key_ready_d = key_ready_q;
      if (load_go) begin
         busy_d      = 1'b1;
         key_ready_d = 1'b0;
      end
      if (exp_last) begin
         busy_d      = 1'b0;
         key_ready_d = 1'b1;
      end
      done_d     = exp_last || (accept_start && reuse_hit);
      rk_valid_d = bus.rk_req && key_ready_q && (bus.rk_idx <= 4'(NR)) && !accept_start;
      rk_err_d   = bus.rk_req && !rk_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_ready_q <= 1'b0;
         rk_valid_q  <= 1'b0;
         rk_err_q    <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_ready_q <= key_ready_d;
         rk_valid_q  <= rk_valid_d;
         rk_err_q    <= rk_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_q    <= '0;
         k_q    <= 3'd0;
         rcon_q <= 8'h01;
      end else if (state_q == LOAD) begin
         i_q    <= IW'(NK);
         k_q    <= 3'd0;
         rcon_q <= 8'h01;
      end else if (wr_en) begin
         i_q <= i_q + IW'(1);
         k_q <= (k_q == 3'(NK - 1)) ? 3'd0 : k_q + 3'd1;
         if (k_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
   end

   // Key words land in the buffer on the accepting edge, so no separate key copy is needed.
   always_ff @(posedge clk) begin
      if (load_go) begin
         for (int j = 0; j < NK; j++) wbuf_q[j] <= bus.key[32*(NK-j)-1 -: 32];
      end
      if (wr_en) wbuf_q[i_q] <= new_w;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rk_data_q <= '0;
      else if (rk_valid_d)
         rk_data_q <= {wbuf_q[rd_base], wbuf_q[rd_base + IW'(1)],
                       wbuf_q[rd_base + IW'(2)], wbuf_q[rd_base + IW'(3)]};
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.key_ready = key_ready_q;
   assign bus.rk_valid  = rk_valid_q;
   assign bus.rk_err    = rk_err_q;
   assign bus.rk_data   = rk_data_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: AES-128 and AES-256 instances, FIPS-197 vectors,
// read-port errors, reset abort, ignored restart, and the KEY_SCHED_REUSE_EN restart path.
module tb_aes_key_sched_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_key_sched_ctrl_if #(.NK(4)) ifa ();
   aes_key_sched_ctrl_if #(.NK(8)) ifb ();

   aes_key_sched_ctrl #(.NK(4), .NR(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   aes_key_sched_ctrl #(.NK(8), .NR(14)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
   localparam logic [255:0] KB   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] KB1  = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] KB2  = 128'ha573c29fa176c498a97fce93a572c09c;
   localparam logic [127:0] KB14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [127:0] k);
      ifa.key   = k;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
   endtask

   task automatic wait_done(input bit sel_b, inout int n);
      while (n < 100 && (sel_b ? ifb.done : ifa.done) !== 1'b1) begin
         tick();
         n++;
      end
   endtask

   task automatic read_a(input int idx);
      ifa.rk_req = 1'b1;
      ifa.rk_idx = 4'(idx);
      tick();
      ifa.rk_req = 1'b0;
   endtask

   task automatic read_b(input int idx);
      ifb.rk_req = 1'b1;
      ifb.rk_idx = 4'(idx);
      tick();
      ifb.rk_req = 1'b0;
   endtask

   initial begin
      int n;
      int vcount;
      int dcount;
      rst = 1'b1;
      ifa.start = 1'b0; ifa.key = '0; ifa.rk_req = 1'b0; ifa.rk_idx = '0;
      ifb.start = 1'b0; ifb.key = '0; ifb.rk_req = 1'b0; ifb.rk_idx = '0;
      tick();
      tick();
      chk("rst_busy", ifa.busy, 0);
      chk("rst_done", ifa.done, 0);
      chk("rst_key_ready", ifa.key_ready, 0);
      chk("rst_rk_valid", ifa.rk_valid, 0);
      chk("rst_rk_err", ifa.rk_err, 0);
      chk("rst_rk_data", ifa.rk_data, 0);
      chk("rst_b_key_ready", ifb.key_ready, 0);
      rst = 1'b0;
      tick();

      read_a(0);
      chk("idle_read_err", ifa.rk_err, 1);
      chk("idle_read_valid", ifa.rk_valid, 0);

      // AES-128 expansion with a read attempt while loading
      start_a(KA);
      chk("busy_after_start", ifa.busy, 1);
      ifa.rk_req = 1'b1;
      ifa.rk_idx = 4'd0;
      tick();
      ifa.rk_req = 1'b0;
      n = 1;
      chk("load_read_err", ifa.rk_err, 1);
      chk("load_read_valid", ifa.rk_valid, 0);
      chk("load_key_ready", ifa.key_ready, 0);
      wait_done(1'b0, n);
      chk("a128_latency", n, 42);
      chk("a128_key_ready", ifa.key_ready, 1);
      chk("a128_busy_clear", ifa.busy, 0);
      tick();
      chk("a128_done_pulse", ifa.done, 0);

      read_a(10);
      chk("a128_idx10_valid", ifa.rk_valid, 1);
      chk("a128_idx10_data", ifa.rk_data, RK10);
      read_a(0);
      chk("a128_idx0_data", ifa.rk_data, KA);
      read_a(1);
      chk("a128_idx1_data", ifa.rk_data, RK1);
      read_a(2);
      chk("a128_idx2_data", ifa.rk_data, RK2);
      read_a(11);
      chk("idx11_err", ifa.rk_err, 1);
      chk("idx11_valid", ifa.rk_valid, 0);
      chk("idx11_data_held", ifa.rk_data, RK2);

      vcount = 0;
      for (int j = 0; j <= 10; j++) begin
         ifa.rk_req = 1'b1;
         ifa.rk_idx = 4'(j);
         tick();
         if (ifa.rk_valid === 1'b1) vcount++;
      end
      ifa.rk_req = 1'b0;
      chk("b2b_valid_count", vcount, 11);
      chk("b2b_last_data", ifa.rk_data, RK10);

      // Restart with the same key while a read is requested in READY
      ifa.rk_req = 1'b1;
      ifa.rk_idx = 4'd3;
      start_a(KA);
      ifa.rk_req = 1'b0;
      chk("start_vs_req_err", ifa.rk_err, 1);
      chk("start_vs_req_valid", ifa.rk_valid, 0);
`ifdef KEY_SCHED_REUSE_EN
      chk("reuse_done", ifa.done, 1);
      chk("reuse_key_ready", ifa.key_ready, 1);
      chk("reuse_busy", ifa.busy, 0);
      tick();
      chk("reuse_done_pulse", ifa.done, 0);
      chk("reuse_key_ready_hold", ifa.key_ready, 1);
`else
      chk("restart_done", ifa.done, 0);
      chk("restart_key_ready_drop", ifa.key_ready, 0);
      chk("restart_busy", ifa.busy, 1);
      n = 0;
      wait_done(1'b0, n);
      chk("restart_latency", n, 42);
`endif

      // Zero key from READY; a second start mid-expansion must be ignored
      start_a('0);
      n = 0;
      while (n < 10) begin
         tick();
         n++;
      end
      ifa.key   = KA;
      ifa.start = 1'b1;
      tick();
      n++;
      ifa.start = 1'b0;
      chk("ignored_start_busy", ifa.busy, 1);
      wait_done(1'b0, n);
      chk("zero_latency", n, 42);
      read_a(1);
      chk("zero_idx1_data", ifa.rk_data, ZK1);
      read_a(2);
      chk("zero_idx2_data", ifa.rk_data, ZK2);

      // Reset at cycle 20 of an expansion
      start_a(KA);
      n = 0;
      while (n < 19) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", ifa.busy, 0);
      chk("abort_done", ifa.done, 0);
      chk("abort_key_ready", ifa.key_ready, 0);
      chk("abort_rk_valid", ifa.rk_valid, 0);
      chk("abort_rk_err", ifa.rk_err, 0);
      chk("abort_rk_data", ifa.rk_data, 0);
      dcount = 0;
      for (int j = 0; j < 60; j++) begin
         tick();
         if (ifa.done === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      start_a(KA);
      n = 0;
      wait_done(1'b0, n);
      chk("post_abort_latency", n, 42);
      read_a(10);
      chk("post_abort_idx10", ifa.rk_data, RK10);

      // AES-256 instance
      ifb.key   = KB;
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      n = 0;
      wait_done(1'b1, n);
      chk("a256_latency", n, 54);
      read_b(14);
      chk("a256_idx14_valid", ifb.rk_valid, 1);
      chk("a256_idx14_data", ifb.rk_data, KB14);
      read_b(1);
      chk("a256_idx1_data", ifb.rk_data, KB1);
      read_b(2);
      chk("a256_idx2_data", ifb.rk_data, KB2);
      read_b(15);
      chk("a256_idx15_err", ifb.rk_err, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
